fp_div_seq: RTL and testbench

Iterative IEEE-754-style floating-point divider, parameterised on total width `n` and exponent width `m`. It is the inverse-direction companion to the combinational multiplier in the ALU. It computes `out = a / b` with a restoring mantissa divider, one quotient bit per clock, behind a start/ready/done handshake. Rounding, special-value, and flush-to-zero conventions match the multiplier, so the two units are interchangeable at the ALU result mux.

---
 rtl/fp_div_seq.sv | 130 +++++++++++++
 tb/tb_fp_div_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: restoring mantissa division, one quotient bit per clock.
// Truncating, flush-to-zero, no Inf/NaN; matches the ALU multiplier's conventions.
module fp_div_seq #(
  parameter int n = 32,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [n-1:0] out,
  output logic [1:0]   dbg_state
);

  localparam int F    = n - m - 1;
  localparam int BIAS = 2**(m-1) - 1;
  localparam int CW   = $clog2(F + 3);
  localparam logic [m+1:0] BIAS_E = (m+2)'(BIAS);
  localparam logic [m+1:0] EMAX   = (m+2)'(2**m - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [F+2:0]   r_q, r_d;
  logic [F:0]     d_q, d_d;
  logic [F+1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [m+1:0]   e_q, e_d;
  logic           sign_q, sign_d;
  logic           zero_q, zero_d;
  logic [n-1:0]   out_q, out_d;
  logic           done_q, done_d;

  logic [F+2:0]   sub;
  logic [m+1:0]   e_n;
  logic [F-1:0]   mant;

  // Handshake: start is taken on any rising edge where ready=1; done pulses for
  // one cycle with out valid, and ready is already high in that same cycle.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    out_d   = out_q;
    done_d  = 1'b0;
    sub     = r_q - {2'b00, d_q};
    e_n     = e_q;
    mant    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = {2'b00, 1'b1, a[F-1:0]};
          d_d     = {1'b1, b[F-1:0]};
          q_d     = '0;
          cnt_d   = '0;
          e_d     = {2'b00, a[n-2:F]} - {2'b00, b[n-2:F]} + BIAS_E;
          sign_d  = a[n-1] ^ b[n-1];
          zero_d  = (a == '0) || (b == '0);
          state_d = DIV;
        end
      end
      DIV: begin
        if (r_q >= {2'b00, d_q}) begin
          q_d = {q_q[F:0], 1'b1};
          r_d = sub << 1;
        end else begin
          q_d = {q_q[F:0], 1'b0};
          r_d = r_q << 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(F + 1)) state_d = NORM;
      end
      NORM: begin
        // Quotient lies in (0.5, 2): a leading zero means one extra left shift.
        if (q_q[F+1]) begin
          mant = q_q[F:1];
        end else begin
          mant = q_q[F-1:0];
          e_n  = e_q - 1'b1;
        end
        if (zero_q || e_n[m+1] || (e_n == '0) || (e_n >= EMAX)) out_d = '0;
        else out_d = {sign_q, e_n[m-1:0], mant};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    r_q    <= r_d;
    d_q    <= d_d;
    q_q    <= q_d;
    cnt_q  <= cnt_d;
    e_q    <= e_d;
    sign_q <= sign_d;
    zero_q <= zero_d;
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed and randomised checks of fp_div_seq: results, fixed latency, handshake,
// ignored starts, back-to-back issue and reset abort.
module tb_fp_div_seq;

  localparam int N   = 32;
  localparam int M   = 8;
  localparam int F   = N - M - 1;
  localparam int LAT = F + 3;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a, b, out;
  logic         ready, done;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_out;

  fp_div_seq #(.n(N), .m(M)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .out(out), .dbg_state(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer quotient of the two significands scaled by 2^(F+1).
  function automatic logic [N-1:0] ref_div(input logic [N-1:0] x, input logic [N-1:0] y);
    longint num, den, q;
    int e;
    logic [F-1:0] mt;
    if (x == '0 || y == '0) return '0;
    num = {40'd0, 1'b1, x[F-1:0]};
    num = num << (F + 1);
    den = {40'd0, 1'b1, y[F-1:0]};
    q   = num / den;
    e   = int'(x[N-2:F]) - int'(y[N-2:F]) + 127;
    if (q[F+1]) mt = q[F:1];
    else begin
      mt = q[F-1:0];
      e--;
    end
    if (e >= 255 || e <= 0) return '0;
    return {x[N-1] ^ y[N-1], e[M-1:0], mt};
  endfunction

  // driver: called at a negedge, start is sampled on the following posedge
  task automatic launch(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic [N-1:0] e);
    check("ready_at_start", {31'd0, ready}, 32'd1);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_result(input string tag, input bit noisy);
    int cnt;
    bit rdy_high;
    logic [N-1:0] e;
    cnt      = 0;
    rdy_high = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    while (!done && cnt < LAT + 20) begin
      if (ready) rdy_high = 1'b1;
      if (noisy && (cnt == 5 || cnt == 12)) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cnt, LAT);
    check({tag, "_ready_busy"}, {31'd0, rdy_high}, 32'd0);
    check({tag, "_ready_done"}, {31'd0, ready}, 32'd1);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
    check({tag, "_out"}, out, e);
    last_out = e;
  endtask

  task automatic op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                    input logic [N-1:0] e, input bit noisy);
    @(negedge clk);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_out_hold"}, out, last_out);
    launch(ta, tb_v, e);
    wait_result(tag, noisy);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [N-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    last_out = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // reset and start on the same edge: start dropped
    start = 1'b1; a = 32'h40C00000; b = 32'h40000000;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_ready", {31'd0, ready}, 32'd1);
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done || !ready) seen = 1'b1;
    end
    check("rst_start_dropped", {31'd0, seen}, 32'd0);

    op("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    op("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    op("neg_sign", 32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0);
    op("sign_recip", 32'h40200000, 32'hC0F00000, 32'hBEAAAAAA, 1'b0);
    op("zero_dividend", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0);
    op("div_by_zero", 32'h40000000, 32'h00000000, 32'h00000000, 1'b0);
    op("overflow", 32'h7F000000, 32'h00800000, 32'h00000000, 1'b0);
    op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0);

    // starts during busy period ignored, operands not re-sampled
    op("ignored_start", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);

    // back-to-back: start in the done cycle
    op("b2b_first", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);
    launch(32'hC0F00000, 32'h40200000, 32'hC0400000);
    wait_result("b2b_second", 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      op($sformatf("rand%0d", i), ra, rb, ref_div(ra, rb), 1'b0);
    end

    // reset mid-operation: aborted, no done
    @(negedge clk);
    launch(32'h40C00000, 32'h40000000, 32'h40400000);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_out", out, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    seen = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    last_out = '0;
    op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

    @(negedge clk);
    check("final_done_low", {31'd0, done}, 32'd0);
    check("final_out_hold", out, last_out);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
